// File: rtl/ced_state_checker.sv
// rtl/ced_state_checker.sv - column-serial CED comparator for the inverse alpha stage
module ced_state_checker #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0][3:0][7:0]   chk_state,
    input  logic [3:0][3:0][7:0]   ref_state,
    input  logic                   clear_err,
    output logic                   busy,
    output logic                   done,
    output logic                   err_now,
    output logic [3:0]             err_col_mask,
    output logic                   err_flag,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             r_col;
    logic [3:0][3:0][7:0]   r_chk;
    logic [3:0][3:0][7:0]   r_ref;
    logic [3:0]             r_acc;
    logic [3:0]             r_mask;
    logic                   r_flag;
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_col_diff;
    logic                   w_report;
    logic                   w_report_err;

    always_comb begin
        w_col_diff = 1'b0;
        for (int r = 0; r < 4; r++) begin
            if (r_chk[r][r_col] != r_ref[r][r_col]) begin
                w_col_diff = 1'b1;
            end
        end
    end

    assign w_report     = (r_state == S_REPORT);
    assign w_report_err = w_report && (r_acc != 4'b0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= 2'd0;
            r_chk   <= '0;
            r_ref   <= '0;
            r_acc   <= 4'b0000;
            r_mask  <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_chk   <= chk_state;
                        r_ref   <= ref_state;
                        r_acc   <= 4'b0000;
                        r_col   <= 2'd0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_col_diff) begin
                        r_acc[r_col] <= 1'b1;
                    end
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    r_mask  <= r_acc;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // A fresh error outranks a simultaneous clear, so the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end else if (w_report_err) begin
            r_flag <= 1'b1;
            if (clear_err) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (clear_err) begin
            r_flag <= 1'b0;
            r_cnt  <= '0;
        end
    end

    assign in_ready     = (r_state == S_IDLE);
    assign busy         = (r_state == S_CHECK) || w_report;
    assign done         = w_report;
    assign err_now      = w_report_err;
    assign err_col_mask = r_mask;
    assign err_flag     = r_flag;
    assign err_cnt      = r_cnt;

endmodule

// File: tb/tb_ced_state_checker.sv
// tb/tb_ced_state_checker.sv - directed self-checking bench for ced_state_checker
module tb_ced_state_checker;

    typedef logic [3:0][3:0][7:0] st_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    st_t         chk_state;
    st_t         ref_state;
    logic        clear_err;
    logic        busy;
    logic        done;
    logic        err_now;
    logic [3:0]  err_col_mask;
    logic        err_flag;
    logic [1:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ced_state_checker #(.CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .chk_state    (chk_state),
        .ref_state    (ref_state),
        .clear_err    (clear_err),
        .busy         (busy),
        .done         (done),
        .err_now      (err_now),
        .err_col_mask (err_col_mask),
        .err_flag     (err_flag),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic st_t base_state();
        st_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = 8'(8'h10 * r + c);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a pair, take the accept edge, and return in cycle T+1.
    task automatic accept(input st_t c, input st_t r);
        chk_state = c;
        ref_state = r;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Called in cycle T+1; returns in the first cycle with done high (or bound).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_idle_regs(input string tag, input logic flag, input logic [1:0] cnt,
                                   input logic [3:0] mask);
        check({tag, "_rdy"},  32'(in_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_flag"}, 32'(err_flag), 32'(flag));
        check({tag, "_cnt"},  32'(err_cnt), 32'(cnt));
        check({tag, "_mask"}, 32'(err_col_mask), 32'(mask));
    endtask

    initial begin
        st_t r0;
        st_t c0;
        int  lat;
        logic saw_done;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        clear_err = 1'b0;
        chk_state = '0;
        ref_state = '0;
        r0        = base_state();

        // 1: reset values
        #1;
        check("rst_done", 32'(done), 0);
        check("rst_errnow", 32'(err_now), 0);
        check_idle_regs("rst", 1'b0, 2'd0, 4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_regs("idle", 1'b0, 2'd0, 4'b0000);

        // 2: matching states
        accept(r0, r0);
        check("t2_busy", 32'(busy), 1);
        wait_done(lat);
        check("t2_lat", 32'(lat), 5);
        check("t2_errnow", 32'(err_now), 0);
        tick();
        check_idle_regs("t2", 1'b0, 2'd0, 4'b0000);

        // 3: single-byte fault in column 3
        c0 = r0;
        c0[2][3] = c0[2][3] ^ 8'h01;
        accept(c0, r0);
        wait_done(lat);
        check("t3_lat", 32'(lat), 5);
        check("t3_errnow", 32'(err_now), 1);
        tick();
        check_idle_regs("t3", 1'b1, 2'd1, 4'b1000);

        // 1b: reset asserted mid-CHECK
        c0 = ~r0;
        accept(c0, r0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_done", 32'(done), 0);
        check_idle_regs("rstmid", 1'b0, 2'd0, 4'b0000);
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("rstmid_nodone", 32'(saw_done), 0);
        check("rstmid_busy", 32'(busy), 0);

        // 4: multi-column fault, in_valid held, chk_state changed while busy
        c0 = r0;
        c0[0][0] = c0[0][0] ^ 8'h80;
        c0[3][2] = c0[3][2] ^ 8'h3C;
        chk_state = c0;
        ref_state = r0;
        in_valid  = 1'b1;
        tick();
        chk_state = ~r0;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("t4_rdy%0d", i), 32'(in_ready), 0);
            if (i == 5) begin
                check("t4_done", 32'(done), 1);
                check("t4_errnow", 32'(err_now), 1);
            end
            tick();
        end
        check("t4_rdy6", 32'(in_ready), 1);
        check("t4_mask", 32'(err_col_mask), 32'(4'b0101));
        check("t4_cnt", 32'(err_cnt), 1);
        tick();
        in_valid = 1'b0;
        check("t4_reaccept", 32'(busy), 1);
        wait_done(lat);
        check("t4b_lat", 32'(lat), 5);
        tick();
        check_idle_regs("t4b", 1'b1, 2'd2, 4'b1111);

        // 6B: clear in IDLE leaves the mask alone
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_idle_regs("t6b", 1'b0, 2'd0, 4'b1111);

        // 5: saturation with a 2-bit counter
        c0 = r0;
        c0[1][1] = c0[1][1] ^ 8'h40;
        for (int k = 1; k <= 5; k++) begin
            accept(c0, r0);
            wait_done(lat);
            tick();
            check($sformatf("t5_cnt%0d", k), 32'(err_cnt), (k < 3) ? k : 3);
            check($sformatf("t5_flag%0d", k), 32'(err_flag), 1);
        end
        check("t5_mask", 32'(err_col_mask), 32'(4'b0010));

        // 6A: clear coincident with an erroring REPORT
        accept(c0, r0);
        wait_done(lat);
        check("t6a_done", 32'(done), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t6a_flag", 32'(err_flag), 1);
        check("t6a_cnt", 32'(err_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ced_state_checker.md
Name: ced_state_checker

Overview:
- Concurrent-error-detection checker directly downstream of the inverse alpha permutation stage.
- Captures the recomputed state (the inverse alpha output) together with the reference state held by the round register.
- Compares the two states one column per cycle and reports per-column mismatches.
- Keeps a sticky error flag and a saturating error counter for the AES datapath fault monitor.

Parameters:
- CNT_W, 8, width of saturating mismatch-event counter err_cnt (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  chk_state/ref_state valid this cycle.
- in_ready  output  1  checker can accept a new pair (high only in IDLE).
- chk_state  input  [7:0] x [3:0][3:0]  recomputed state from inverse alpha output, indexed [row][col].
- ref_state  input  [7:0] x [3:0][3:0]  reference state, same indexing.
- clear_err  input  1  synchronous clear of err_flag and err_cnt.
- busy  output  1  high in CHECK and REPORT.
- done  output  1  one-cycle pulse, REPORT state.
- err_now  output  1  valid with done: any column mismatched in this check.
- err_col_mask  output  4  bit c set if any byte in column c mismatched; held until next REPORT.
- err_flag  output  1  sticky: set on any reported mismatch.
- err_cnt  output  CNT_W  count of checks with err_now=1, saturating.

Behaviour:
- Reset (async, rst_n low): state=IDLE, col=0, capture registers=0, mask accumulator=0.
- Outputs during reset: in_ready=1, busy=0, done=0, err_now=0, err_col_mask=0, err_flag=0, err_cnt=0.
- FSM has three states: IDLE, CHECK, REPORT.
- IDLE: in_ready=1. On in_valid && in_ready at edge T:
  - register both states (256 bits);
  - clear the mask accumulator;
  - set col=0;
  - go to CHECK.
- CHECK: 4 cycles (T+1..T+4). Each cycle:
  - compare captured bytes [0..3][col];
  - set accumulator bit col if any of the 4 bytes differ;
  - increment col.
  - When col==3, go to REPORT.
- REPORT: cycle T+5.
  - done=1, err_now = |accumulator (combinational from the accumulator).
  - At the REPORT edge, err_col_mask <= accumulator.
  - If the accumulator is nonzero: err_flag <= 1, and err_cnt increments unless it is all ones (saturates).
  - Next state is IDLE. The earliest next accept is the edge ending cycle T+6.
- Latency: accept edge to done = 5 cycles. Throughput: one check per 6 cycles.
- in_valid while busy: ignored and not buffered. Inputs are sampled only at the accept edge; later changes on chk_state/ref_state have no effect.
- err_col_mask is registered. It updates at the REPORT edge and is stable from T+6 until the next REPORT edge.
- clear_err (any state): at the next edge, err_flag <= 0 and err_cnt <= 0. It does not affect err_col_mask or an in-flight check.
- clear_err in the same cycle as an erroring REPORT: the new error wins, giving err_flag=1 and err_cnt=1.
- Reset mid-CHECK or mid-REPORT: immediate return to reset values. No done pulse follows, and partial results are discarded.
- Comparison is exact 8-bit equality per byte. Column c comprises bytes [0][c], [1][c], [2][c], [3][c].

Test Plan:
1. Reset, then idle.
   - Required: in_ready=1, busy=0, done=0, err_flag=0, err_cnt=0, err_col_mask=0.
   - Assert rst_n low mid-CHECK: outputs return to these values immediately and no done pulse follows.
2. Matching states.
   - Stimulus: ref_state=chk_state, with byte [r][c] = 8'h10*r + c.
   - Required: done exactly 5 cycles after accept, err_now=0, err_col_mask=4'b0000, err_cnt=0, err_flag=0.
3. Single-byte fault.
   - Stimulus: chk_state[2][3] = ref_state[2][3] ^ 8'h01.
   - Required: err_now=1 with done; err_col_mask=4'b1000 from the next cycle; err_flag=1; err_cnt=1.
4. Multi-column fault, with input changes while busy.
   - Stimulus: mismatches at [0][0] and [3][2]. Hold in_valid high throughout, and change chk_state while busy.
   - Required: mask=4'b0101; changes after the accept edge have no effect; in_ready=0 for 5 cycles; the second accept occurs 6 cycles after the first.
5. Counter saturation.
   - Stimulus: CNT_W=2, 5 consecutive faulty checks.
   - Required: err_cnt sequence 1,2,3,3,3; err_flag stays 1.
6. clear_err interaction.
   - Stimulus A: clear_err asserted in the REPORT cycle of a faulty check. Required: err_flag=1, err_cnt=1.
   - Stimulus B: clear_err asserted in IDLE. Required: err_flag=0, err_cnt=0, err_col_mask unchanged.
